// File: rtl/arf_sequencer.sv
// Micro-sequencer for the PC/SP/AR address register file: accepts one address
// operation per handshake and drives register-file selects and memory strobes.
module arf_sequencer #(
  parameter logic [15:0] STACK_TOP   = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  output logic        op_ready,
  output logic        op_done,
  output logic        op_err,
  input  logic [15:0] sp_q,
  output logic [2:0]  RegSel,
  output logic [1:0]  FunSel,
  output logic [1:0]  OutCSel,
  output logic [1:0]  OutDSel,
  output logic        i_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        wr_pc_sel
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_ADDR, S_MEM, S_INC, S_LOAD, S_FIN
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP, OP_FETCH, OP_JUMP, OP_LDAR, OP_PUSH, OP_POP, OP_CALL, OP_RET
  } op_e;

  localparam logic [2:0] EN_PC    = 3'b100;
  localparam logic [2:0] EN_SP    = 3'b010;
  localparam logic [2:0] EN_AR    = 3'b001;
  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] SEL_PC   = 2'b00;
  localparam logic [1:0] SEL_SP   = 2'b01;

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   err_q, err_d;

  op_e    op_in;
  logic   bound_hit;
  logic   stack_op;

  function automatic state_e first_state(op_e op);
    case (op)
      OP_FETCH, OP_POP, OP_RET: first_state = S_ADDR;
      OP_JUMP, OP_LDAR:         first_state = S_LOAD;
      OP_PUSH, OP_CALL:         first_state = S_DEC;
      default:                  first_state = S_FIN;
    endcase
  endfunction

  assign op_in = op_e'(op_code);

  // Bounds are judged on the SP value present at the accepting edge.
  assign bound_hit = ((op_in == OP_PUSH || op_in == OP_CALL) && sp_q == STACK_LIMIT) ||
                     ((op_in == OP_POP  || op_in == OP_RET ) && sp_q == STACK_TOP);

  assign stack_op = (op_q == OP_PUSH) || (op_q == OP_POP) ||
                    (op_q == OP_CALL) || (op_q == OP_RET);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d    = op_in;
          err_d   = bound_hit;
          state_d = bound_hit ? S_FIN : first_state(op_in);
        end
      end
      S_DEC:  state_d = S_ADDR;
      S_ADDR: state_d = S_MEM;
      S_MEM: begin
        case (op_q)
          OP_FETCH, OP_POP: state_d = S_INC;
          OP_CALL, OP_RET:  state_d = S_LOAD;
          default:          state_d = S_FIN;
        endcase
      end
      S_INC:  state_d = S_FIN;
      S_LOAD: state_d = (op_q == OP_RET) ? S_INC : S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    RegSel    = 3'b000;
    FunSel    = FUN_DEC;
    OutCSel   = SEL_PC;
    OutDSel   = SEL_PC;
    i_sel     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    wr_pc_sel = 1'b0;
    op_done   = 1'b0;
    op_err    = 1'b0;

    // Address selects stay on the op's source for its whole duration, since
    // the register file shows a select one cycle after it is driven.
    if (state_q != S_IDLE && stack_op && !err_q) OutDSel = SEL_SP;

    case (state_q)
      S_DEC: begin
        RegSel = EN_SP;
        FunSel = FUN_DEC;
      end
      S_MEM: begin
        mem_rd    = (op_q == OP_FETCH) || (op_q == OP_POP) || (op_q == OP_RET);
        mem_wr    = (op_q == OP_PUSH) || (op_q == OP_CALL);
        wr_pc_sel = (op_q == OP_CALL);
      end
      S_INC: begin
        RegSel = (op_q == OP_FETCH) ? EN_PC : EN_SP;
        FunSel = FUN_INC;
      end
      S_LOAD: begin
        RegSel = (op_q == OP_LDAR) ? EN_AR : EN_PC;
        FunSel = FUN_LOAD;
        i_sel  = (op_q == OP_RET);
      end
      S_FIN: begin
        op_done = 1'b1;
        op_err  = err_q;
      end
      default: ;
    endcase
  end

  assign op_ready = (state_q == S_IDLE) && !reset;

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: a register-file/memory plant follows the DUT controls,
// and results are compared against vector tables and an op-level stack model.
module tb_arf_sequencer;

  localparam logic [15:0] TOP   = 16'hFFFF;
  localparam logic [15:0] LIMIT = 16'hFF00;
  localparam logic [2:0] NOP = 3'd0, FETCH = 3'd1, JUMP = 3'd2, LDAR = 3'd3,
                         PUSH = 3'd4, POP = 3'd5, CALL = 3'd6, RET = 3'd7;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic        op_ready, op_done, op_err;
  logic [15:0] sp_q;
  logic [2:0]  RegSel;
  logic [1:0]  FunSel, OutCSel, OutDSel;
  logic        i_sel, mem_rd, mem_wr, wr_pc_sel;

  always #5 clock = ~clock;

  arf_sequencer #(.STACK_TOP(TOP), .STACK_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .op_done(op_done), .op_err(op_err), .sp_q(sp_q),
    .RegSel(RegSel), .FunSel(FunSel), .OutCSel(OutCSel), .OutDSel(OutDSel),
    .i_sel(i_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .wr_pc_sel(wr_pc_sel)
  );

  // ---------------- register file + memory plant ----------------
  logic [15:0] pc_r, sp_r, ar_r, outc_r, outd_r, rdata_r;
  logic [15:0] target_bus, ext_data, i_bus;
  logic [15:0] mem [0:65535];
  logic        pre_en, mem_clr;
  logic [15:0] pre_pc, pre_sp, pre_ar;

  assign sp_q  = sp_r;
  assign i_bus = i_sel ? rdata_r : target_bus;

  function automatic logic [15:0] apply_fun(logic [15:0] q, logic [1:0] fs, logic [15:0] i);
    case (fs)
      2'b00:   return q - 16'd1;
      2'b01:   return q + 16'd1;
      2'b10:   return i;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pick(logic [1:0] s);
    case (s)
      2'b00:   return pc_r;
      2'b01:   return sp_r;
      2'b10:   return ar_r;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clock) begin
    if (pre_en) begin
      pc_r <= pre_pc;
      sp_r <= pre_sp;
      ar_r <= pre_ar;
    end else begin
      if (RegSel[2]) pc_r <= apply_fun(pc_r, FunSel, i_bus);
      if (RegSel[1]) sp_r <= apply_fun(sp_r, FunSel, i_bus);
      if (RegSel[0]) ar_r <= apply_fun(ar_r, FunSel, i_bus);
    end
    outc_r <= pick(OutCSel);
    outd_r <= pick(OutDSel);
    if (mem_clr) begin
      for (int a = 0; a < 65536; a++) mem[a] <= 16'h0000;
    end else if (mem_wr) begin
      mem[outd_r] <= wr_pc_sel ? outc_r : ext_data;
    end
    if (mem_rd) rdata_r <= mem[outd_r];
  end

  // ---------------- checking infrastructure ----------------
  typedef struct packed {
    logic [2:0] regsel;
    logic [1:0] funsel, outcsel, outdsel;
    logic       isel, rd, wr, wrpc, done, err;
  } ctl_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] pc, sp, tgt;
    int          lat;
    logic        err;
    logic [15:0] pc_e, sp_e, ar_e;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ctl_t trace[$];
  ctl_t t;
  int   r_lat, r_wait;
  logic r_err, r_to, r_act, r_rdy;

  logic [15:0] m_pc, m_sp, m_ar;
  logic [15:0] m_mem [logic [15:0]];
  int          e_lat;
  logic        e_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic ctl_t ctl_now();
    return '{RegSel, FunSel, OutCSel, OutDSel, i_sel, mem_rd, mem_wr, wr_pc_sel, op_done, op_err};
  endfunction

  function automatic ctl_t tr(int i);
    if (i < trace.size()) return trace[i];
    return '1;
  endfunction

  task automatic preload(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] ar, input bit clr);
    @(negedge clock);
    pre_en = 1'b1; mem_clr = clr;
    pre_pc = pc; pre_sp = sp; pre_ar = ar;
    @(negedge clock);
    pre_en = 1'b0; mem_clr = 1'b0;
    m_pc = pc; m_sp = sp; m_ar = ar;
    if (clr) m_mem.delete();
  endtask

  // Issues one op and follows it to op_done; starts and ends just after a falling edge.
  task automatic run_op(input logic [2:0] op, input logic [15:0] tgt, input logic [15:0] ext, input bit noise);
    r_wait = 0; r_to = 1'b1; r_lat = 0; r_err = 1'b0; r_act = 1'b0; r_rdy = 1'b0;
    trace.delete();
    while (!op_ready && r_wait < 40) begin
      @(negedge clock);
      r_wait++;
    end
    if (!op_ready) return;
    op_valid = 1'b1; op_code = op; target_bus = tgt; ext_data = ext;
    @(negedge clock);
    for (int c = 1; c <= 12; c++) begin
      trace.push_back(ctl_now());
      if (RegSel != 3'b000 || mem_rd || mem_wr) r_act = 1'b1;
      if (op_ready) r_rdy = 1'b1;
      op_valid = noise;
      if (noise) op_code = 3'($urandom);
      if (op_done) begin
        r_lat = c; r_err = op_err; r_to = 1'b0; op_valid = 1'b0;
        break;
      end
      @(negedge clock);
    end
    op_valid = 1'b0;
  endtask

  function automatic logic [15:0] m_read(logic [15:0] a);
    return m_mem.exists(a) ? m_mem[a] : 16'h0000;
  endfunction

  // Op-level view of the stack machine: pre-decrement push, read-then-increment pop.
  task automatic model_op(input logic [2:0] op, input logic [15:0] tgt, input logic [15:0] ext);
    e_err = 1'b0;
    e_lat = 1;
    case (op)
      FETCH: begin m_pc = m_pc + 16'd1; e_lat = 4; end
      JUMP:  begin m_pc = tgt; e_lat = 2; end
      LDAR:  begin m_ar = tgt; e_lat = 2; end
      PUSH: begin
        if (m_sp == LIMIT) e_err = 1'b1;
        else begin m_sp = m_sp - 16'd1; m_mem[m_sp] = ext; e_lat = 4; end
      end
      POP: begin
        if (m_sp == TOP) e_err = 1'b1;
        else begin m_sp = m_sp + 16'd1; e_lat = 4; end
      end
      CALL: begin
        if (m_sp == LIMIT) e_err = 1'b1;
        else begin m_sp = m_sp - 16'd1; m_mem[m_sp] = m_pc; m_pc = tgt; e_lat = 5; end
      end
      RET: begin
        if (m_sp == TOP) e_err = 1'b1;
        else begin m_pc = m_read(m_sp); m_sp = m_sp + 16'd1; e_lat = 5; end
      end
      default: e_lat = 1;
    endcase
  endtask

  vec_t        vecs[14];
  logic [2:0]  r_op;
  logic [15:0] r_tgt, r_ext, r_sp;
  bit          r_noise;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{NOP,   16'h0010, 16'hFFFF, 16'h0000, 1, 1'b0, 16'h0010, 16'hFFFF, 16'h1234};
    vecs[1]  = '{FETCH, 16'h0010, 16'hFFFF, 16'h0000, 4, 1'b0, 16'h0011, 16'hFFFF, 16'h1234};
    vecs[2]  = '{FETCH, 16'hFFFF, 16'hFF80, 16'h0000, 4, 1'b0, 16'h0000, 16'hFF80, 16'h1234};
    vecs[3]  = '{JUMP,  16'h0010, 16'hFFFF, 16'h0300, 2, 1'b0, 16'h0300, 16'hFFFF, 16'h1234};
    vecs[4]  = '{LDAR,  16'h0010, 16'hFFFF, 16'hABCD, 2, 1'b0, 16'h0010, 16'hFFFF, 16'hABCD};
    vecs[5]  = '{PUSH,  16'h0010, 16'hFFFF, 16'h0000, 4, 1'b0, 16'h0010, 16'hFFFE, 16'h1234};
    vecs[6]  = '{PUSH,  16'h0010, 16'hFF00, 16'h0000, 1, 1'b1, 16'h0010, 16'hFF00, 16'h1234};
    vecs[7]  = '{PUSH,  16'h0010, 16'hFF01, 16'h0000, 4, 1'b0, 16'h0010, 16'hFF00, 16'h1234};
    vecs[8]  = '{POP,   16'h0010, 16'hFFFF, 16'h0000, 1, 1'b1, 16'h0010, 16'hFFFF, 16'h1234};
    vecs[9]  = '{POP,   16'h0010, 16'hFF80, 16'h0000, 4, 1'b0, 16'h0010, 16'hFF81, 16'h1234};
    vecs[10] = '{CALL,  16'h0050, 16'hFFFF, 16'h0200, 5, 1'b0, 16'h0200, 16'hFFFE, 16'h1234};
    vecs[11] = '{CALL,  16'h0050, 16'hFF00, 16'h0200, 1, 1'b1, 16'h0050, 16'hFF00, 16'h1234};
    vecs[12] = '{RET,   16'h0050, 16'hFFFF, 16'h0200, 1, 1'b1, 16'h0050, 16'hFFFF, 16'h1234};
    vecs[13] = '{RET,   16'h0050, 16'hFF80, 16'h0200, 5, 1'b0, 16'h0000, 16'hFF81, 16'h1234};

    reset = 1'b1; op_valid = 1'b0; op_code = NOP;
    target_bus = 16'h0; ext_data = 16'h0;
    pre_en = 1'b0; mem_clr = 1'b0; pre_pc = 16'h0; pre_sp = 16'h0; pre_ar = 16'h0;

    // Reset state
    #1;
    check("reset_outputs", 32'(ctl_now()), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_ready", op_ready, 1'b1);
    check("reset_outputs_after", 32'(ctl_now()), 32'h0);
    preload(16'h0000, TOP, 16'h0000, 1'b1);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      preload(vecs[i].pc, vecs[i].sp, 16'h1234, 1'b0);
      run_op(vecs[i].op, vecs[i].tgt, 16'h5A5A, 1'b0);
      check($sformatf("vec%0d_timeout", i), r_to, 1'b0);
      check($sformatf("vec%0d_latency", i), r_lat, vecs[i].lat);
      check($sformatf("vec%0d_err", i), r_err, vecs[i].err);
      check($sformatf("vec%0d_pc", i), pc_r, vecs[i].pc_e);
      check($sformatf("vec%0d_sp", i), sp_r, vecs[i].sp_e);
      check($sformatf("vec%0d_ar", i), ar_r, vecs[i].ar_e);
      if (vecs[i].err) check($sformatf("vec%0d_no_activity", i), r_act, 1'b0);
    end

    // FETCH cycle trace
    preload(16'h0010, TOP, 16'h0000, 1'b0);
    run_op(FETCH, 16'h0000, 16'h0000, 1'b0);
    t = tr(0); check("fetch_addr_outd_rd", {t.outdsel, t.rd, t.regsel}, 6'b00_0_000);
    t = tr(1); check("fetch_mem_outd_rd", {t.outdsel, t.rd, t.regsel}, 6'b00_1_000);
    t = tr(2); check("fetch_inc_ctl", {t.regsel, t.funsel, t.rd}, 6'b100_01_0);
    t = tr(3); check("fetch_fin_done", t.done, 1'b1);
    check("fetch_pc", pc_r, 16'h0011);

    // PUSH trace and stored word
    preload(16'h0010, TOP, 16'h0000, 1'b0);
    run_op(PUSH, 16'h0000, 16'hBEEF, 1'b0);
    t = tr(0); check("push_dec_ctl", {t.regsel, t.funsel}, 5'b010_00);
    t = tr(1); check("push_addr_no_wr", {t.wr, t.outdsel}, 3'b0_01);
    t = tr(2); check("push_mem_wr", {t.wr, t.rd, t.outdsel}, 4'b1_0_01);
    check("push_mem_word", mem[16'hFFFE], 16'hBEEF);
    check("push_err", r_err, 1'b0);

    // CALL then back-to-back RET
    preload(16'h0050, TOP, 16'h0000, 1'b0);
    run_op(CALL, 16'h0200, 16'h0000, 1'b0);
    t = tr(2); check("call_mem_wr_pc", {t.wr, t.wrpc}, 2'b11);
    check("call_mem_word", mem[16'hFFFE], 16'h0050);
    check("call_pc", pc_r, 16'h0200);
    run_op(RET, 16'h7777, 16'h0000, 1'b0);
    check("ret_back_to_back_wait", r_wait, 1);
    check("ret_latency", r_lat, 5);
    t = tr(1); check("ret_mem_rd", t.rd, 1'b1);
    t = tr(2); check("ret_load_isel", {t.regsel, t.funsel, t.isel}, 6'b100_10_1);
    check("ret_pc", pc_r, 16'h0050);
    check("ret_sp", sp_r, 16'hFFFF);

    // op_valid with changing op_code while busy, then immediate follow-on op
    preload(16'h0100, 16'hFF40, 16'h0000, 1'b0);
    run_op(FETCH, 16'h0000, 16'h0000, 1'b1);
    check("busy_noise_latency", r_lat, 4);
    check("busy_noise_ready_low", r_rdy, 1'b0);
    check("busy_noise_pc", pc_r, 16'h0101);
    check("busy_noise_sp", sp_r, 16'hFF40);
    run_op(JUMP, 16'h0400, 16'h0000, 1'b0);
    check("b2b_wait", r_wait, 1);
    check("b2b_pc", pc_r, 16'h0400);

    // Reset asserted during the CALL memory cycle
    preload(16'h0066, TOP, 16'h0000, 1'b0);
    op_valid = 1'b1; op_code = CALL; target_bus = 16'h0300;
    @(negedge clock);
    op_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_mid_in_mem", {mem_wr, wr_pc_sel}, 2'b11);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", 32'(ctl_now()), 32'h0);
    check("rst_mid_ready", op_ready, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid_ready_after", op_ready, 1'b1);
    check("rst_mid_pc", pc_r, 16'h0066);
    check("rst_mid_mem", mem[16'hFFFE], 16'h0050);
    run_op(JUMP, 16'h0ABC, 16'h0000, 1'b0);
    check("rst_jump_latency", r_lat, 2);
    check("rst_jump_pc", pc_r, 16'h0ABC);

    // Randomized ops against the stack model
    preload(16'h0000, TOP, 16'h0000, 1'b1);
    for (int n = 0; n < 160; n++) begin
      if (n % 16 == 0) begin
        case ($urandom_range(0, 3))
          0:       r_sp = TOP;
          1:       r_sp = LIMIT;
          2:       r_sp = LIMIT + 16'd1;
          default: r_sp = 16'($urandom_range(32'hFF00, 32'hFFFF));
        endcase
        preload(16'($urandom), r_sp, 16'($urandom), 1'b0);
      end
      r_op    = 3'($urandom);
      r_tgt   = 16'($urandom);
      r_ext   = 16'($urandom);
      r_noise = ($urandom_range(0, 3) == 0);
      model_op(r_op, r_tgt, r_ext);
      run_op(r_op, r_tgt, r_ext, r_noise);
      check($sformatf("rnd%0d_op%0d_timeout", n, r_op), r_to, 1'b0);
      check($sformatf("rnd%0d_op%0d_latency", n, r_op), r_lat, e_lat);
      check($sformatf("rnd%0d_op%0d_err", n, r_op), r_err, e_err);
      check($sformatf("rnd%0d_op%0d_pc", n, r_op), pc_r, m_pc);
      check($sformatf("rnd%0d_op%0d_sp", n, r_op), sp_r, m_sp);
      check($sformatf("rnd%0d_op%0d_ar", n, r_op), ar_r, m_ar);
      check($sformatf("rnd%0d_op%0d_ready_busy", n, r_op), r_rdy, 1'b0);
      if (e_err) check($sformatf("rnd%0d_op%0d_no_activity", n, r_op), r_act, 1'b0);
      if (!e_err && (r_op == PUSH || r_op == CALL))
        check($sformatf("rnd%0d_op%0d_stack_word", n, r_op), mem[m_sp], m_read(m_sp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
